// File: rtl/packed_word_ram.sv
// Packing RAM: narrow elements shift into wide words per entry, with per-entry fill counts.
// Storage is cleared by a sequential sweep (after reset or on clear) so it can map onto block RAM.
module packed_word_ram #(
  parameter  int IN_W  = 8,
  parameter  int LANES = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(LANES + 1),
  localparam int W     = IN_W * LANES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [IN_W-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [W-1:0]    rd_data,
  output logic [CW-1:0]   rd_count,
  output logic            rd_valid,
  output logic            busy,
  output logic            wr_ovf
);

  typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  logic [W-1:0]  word_mem  [DEPTH];
  logic [CW-1:0] count_mem [DEPTH];

  logic          wr_in_range, rd_in_range, wr_room, wr_accept, rd_accept;
  logic [W-1:0]  cur_word, new_word;
  logic [CW-1:0] cur_count, new_count;

  logic [W-1:0]  rd_data_q, rd_data_d;
  logic [CW-1:0] rd_count_q, rd_count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_ovf_q, wr_ovf_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy    = (state_q == ST_SWEEP);
    case (state_q)
      ST_SWEEP: begin
        // A clear during the sweep restarts it from entry 0.
        if (clear) begin
          ptr_d = '0;
        end else if (ptr_q == AW'(DEPTH - 1)) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          ptr_d   = '0;
          state_d = ST_SWEEP;
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Extra address bit keeps the range check meaningful when DEPTH is a power of two.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < (AW + 1)'(DEPTH));
    rd_in_range = ({1'b0, rd_addr} < (AW + 1)'(DEPTH));
    cur_word    = word_mem[wr_addr];
    cur_count   = count_mem[wr_addr];
    wr_room     = (cur_count < CW'(LANES));
    new_word    = (cur_word << IN_W) | W'(wr_data);
    new_count   = cur_count + 1'b1;
    wr_accept   = wr_en && !busy && wr_in_range && wr_room;
    rd_accept   = rd_en && !busy;
    wr_ovf_d    = wr_en && !busy && (!wr_in_range || !wr_room);
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      word_mem[ptr_q]  <= '0;
      count_mem[ptr_q] <= '0;
    end else if (wr_accept) begin
      word_mem[wr_addr]  <= new_word;
      count_mem[wr_addr] <= new_count;
    end
  end

  // Same-address append forwards the post-append word so the read sees it immediately.
  always_comb begin
    rd_valid_d = rd_accept;
    rd_data_d  = rd_data_q;
    rd_count_d = rd_count_q;
    if (rd_accept) begin
      if (!rd_in_range) begin
        rd_data_d  = '0;
        rd_count_d = '0;
      end else if (wr_accept && (wr_addr == rd_addr)) begin
        rd_data_d  = new_word;
        rd_count_d = new_count;
      end else begin
        rd_data_d  = word_mem[rd_addr];
        rd_count_d = count_mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_count_q <= '0;
      rd_valid_q <= 1'b0;
      wr_ovf_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_count_q <= rd_count_d;
      rd_valid_q <= rd_valid_d;
      wr_ovf_q   <= wr_ovf_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_count = rd_count_q;
  assign rd_valid = rd_valid_q;
  assign wr_ovf   = wr_ovf_q;

endmodule

// File: tb/tb_packed_word_ram.sv
// Bench for packed_word_ram: DEPTH=64 and DEPTH=48 instances share stimulus, each
// checked by a scoreboard against a per-entry array model of append/read/clear.
module tb_packed_word_ram;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic [3:0]  cnt;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [5:0]  wr_addr = '0, rd_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [63:0] rd_data0, rd_data1;
  logic [3:0]  rd_count0, rd_count1;
  logic        rd_valid0, rd_valid1, busy0, busy1, wr_ovf0, wr_ovf1;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          busy_n0, busy_n1, guard;

  logic [63:0] m_word [2][64];
  int          m_cnt  [2][64];
  int          m_left [2];
  int          dep    [2] = '{64, 48};

  rd_exp_t     rdq0[$], rdq1[$];
  int          ovq0[$], ovq1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  packed_word_ram #(.IN_W(8), .LANES(8), .DEPTH(64)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_count(rd_count0), .rd_valid(rd_valid0), .busy(busy0), .wr_ovf(wr_ovf0));

  packed_word_ram #(.IN_W(8), .LANES(8), .DEPTH(48)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_count(rd_count1), .rd_valid(rd_valid1), .busy(busy1), .wr_ovf(wr_ovf1));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a sweep blocks accesses for its duration and leaves every entry empty.
  task automatic applyStimulus(input bit clr, input bit we, input int wa, input logic [7:0] wd,
                               input bit re, input int ra);
    rd_exp_t e;
    clear = clr; wr_en = we; wr_addr = 6'(wa); wr_data = wd; rd_en = re; rd_addr = 6'(ra);
    checkOutput("busy0", 64'(busy0), 64'(m_left[0] > 0));
    checkOutput("busy1", 64'(busy1), 64'(m_left[1] > 0));
    for (int i = 0; i < 2; i++) begin
      if (m_left[i] == 0) begin
        if (we) begin
          if (wa >= dep[i] || m_cnt[i][wa] == 8) begin
            if (i == 0) ovq0.push_back(cyc + 1); else ovq1.push_back(cyc + 1);
          end else begin
            m_word[i][wa] = (m_word[i][wa] * 256) + 64'(wd);
            m_cnt[i][wa]  = m_cnt[i][wa] + 1;
          end
        end
        if (re) begin
          e.cyc  = cyc + 1;
          e.data = (ra >= dep[i]) ? 64'd0 : m_word[i][ra];
          e.cnt  = (ra >= dep[i]) ? 4'd0 : 4'(m_cnt[i][ra]);
          if (i == 0) rdq0.push_back(e); else rdq1.push_back(e);
        end
        if (clr) m_left[i] = dep[i];
      end else if (clr) begin
        m_left[i] = dep[i];
      end else begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          for (int a = 0; a < 64; a++) begin
            m_word[i][a] = '0;
            m_cnt[i][a]  = 0;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    rdq0.delete(); rdq1.delete(); ovq0.delete(); ovq1.delete();
    for (int i = 0; i < 2; i++) m_left[i] = dep[i];
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic monitorRead(input int i, input logic v, input logic [63:0] d, input logic [3:0] c);
    rd_exp_t e;
    bit have;
    have = (i == 0) ? (rdq0.size() > 0) : (rdq1.size() > 0);
    if (have) e = (i == 0) ? rdq0[0] : rdq1[0];
    if (v) begin
      if (!have) begin
        checkOutput($sformatf("rd_valid%0d unexpected", i), 64'(v), 64'd0);
      end else begin
        if (i == 0) void'(rdq0.pop_front()); else void'(rdq1.pop_front());
        checkOutput($sformatf("rd_latency%0d", i), 64'(cyc), 64'(e.cyc));
        checkOutput($sformatf("rd_data%0d", i), d, e.data);
        checkOutput($sformatf("rd_count%0d", i), 64'(c), 64'(e.cnt));
      end
    end else if (have && e.cyc <= cyc) begin
      checkOutput($sformatf("rd_valid%0d missing", i), 64'(v), 64'd1);
      if (i == 0) void'(rdq0.pop_front()); else void'(rdq1.pop_front());
    end
  endtask

  task automatic monitorOvf(input int i, input logic o);
    bit have;
    int exp_cyc;
    have = (i == 0) ? (ovq0.size() > 0) : (ovq1.size() > 0);
    exp_cyc = have ? ((i == 0) ? ovq0[0] : ovq1[0]) : 0;
    if (o) begin
      if (!have) begin
        checkOutput($sformatf("wr_ovf%0d unexpected", i), 64'(o), 64'd0);
      end else begin
        if (i == 0) void'(ovq0.pop_front()); else void'(ovq1.pop_front());
        checkOutput($sformatf("wr_ovf%0d cycle", i), 64'(cyc), 64'(exp_cyc));
      end
    end else if (have && exp_cyc <= cyc) begin
      checkOutput($sformatf("wr_ovf%0d missing", i), 64'(o), 64'd1);
      if (i == 0) void'(ovq0.pop_front()); else void'(ovq1.pop_front());
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      monitorRead(0, rd_valid0, rd_data0, rd_count0);
      monitorRead(1, rd_valid1, rd_data1, rd_count1);
      monitorOvf(0, wr_ovf0);
      monitorOvf(1, wr_ovf1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetDut();
    checkOutput("reset rd_valid", 64'(rd_valid0), 64'd0);
    checkOutput("reset busy", 64'(busy0), 64'd1);

    // Read addr 0 throughout the post-reset sweep.
    for (int k = 0; k < 66; k++) applyStimulus(0, 0, 0, 8'h00, 1, 0);
    checkOutput("post-sweep rd_data", rd_data0, 64'd0);
    checkOutput("post-sweep rd_count", 64'(rd_count0), 64'd0);

    for (int k = 1; k <= 8; k++) applyStimulus(0, 1, 5, 8'(k * 17), 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 5);
    checkOutput("full word", rd_data0, 64'h1122334455667788);
    checkOutput("full count", 64'(rd_count0), 64'd8);

    applyStimulus(0, 1, 5, 8'h99, 0, 0);
    checkOutput("ovf pulse", 64'(wr_ovf0), 64'd1);
    applyStimulus(0, 0, 0, 8'h00, 1, 5);
    checkOutput("ovf single", 64'(wr_ovf0), 64'd0);
    checkOutput("ovf word kept", rd_data0, 64'h1122334455667788);

    applyStimulus(0, 1, 3, 8'h01, 0, 0);
    applyStimulus(0, 1, 3, 8'hAB, 1, 3);
    checkOutput("write-through data", rd_data0, 64'h01AB);
    checkOutput("write-through count", 64'(rd_count0), 64'd2);

    // Out-of-range accesses on the DEPTH=48 instance.
    applyStimulus(0, 0, 0, 8'h00, 1, 50);
    checkOutput("oor read valid", 64'(rd_valid1), 64'd1);
    checkOutput("oor read data", rd_data1, 64'd0);
    applyStimulus(0, 1, 50, 8'h5A, 0, 0);
    checkOutput("oor append ovf", 64'(wr_ovf1), 64'd1);

    for (int k = 0; k < 30; k++)
      applyStimulus(0, 1, $urandom_range(0, 63), 8'($urandom), 0, 0);

    // Clear, then restart the sweep on its 10th busy cycle.
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    busy_n0 = 0; busy_n1 = 0;
    for (int k = 0; k < 10; k++) begin
      busy_n0 += int'(busy0); busy_n1 += int'(busy1);
      applyStimulus(k == 9, 1, $urandom_range(0, 63), 8'($urandom), 1, $urandom_range(0, 63));
    end
    guard = 0;
    while ((busy0 || busy1) && guard < 200) begin
      busy_n0 += int'(busy0); busy_n1 += int'(busy1);
      applyStimulus(0, 1, $urandom_range(0, 63), 8'($urandom), 1, $urandom_range(0, 63));
      guard++;
    end
    checkOutput("clear busy edges 64", 64'(busy_n0), 64'd74);
    checkOutput("clear busy edges 48", 64'(busy_n1), 64'd58);
    for (int a = 0; a < 64; a++) applyStimulus(0, 0, 0, 8'h00, 1, a);

    for (int k = 0; k < 500; k++) begin
      applyStimulus($urandom_range(0, 149) == 0, 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 63),
                    8'($urandom), 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 63));
    end
    guard = 0;
    while ((busy0 || busy1) && guard < 200) begin
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
      guard++;
    end

    // Reset while a read result is being presented.
    applyStimulus(0, 0, 0, 8'h00, 1, 5);
    checkOutput("pre-reset rd_valid", 64'(rd_valid1), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid-read reset rd_valid0", 64'(rd_valid0), 64'd0);
    checkOutput("mid-read reset rd_valid1", 64'(rd_valid1), 64'd0);
    checkOutput("mid-read reset rd_data", rd_data1, 64'd0);
    checkOutput("mid-read reset busy", 64'(busy1), 64'd1);
    resetDut();
    for (int k = 0; k < 70; k++) applyStimulus(0, 1, 5, 8'h77, 1, 5);
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 0);

    checkOutput("rdq0 drained", 64'(rdq0.size()), 64'd0);
    checkOutput("rdq1 drained", 64'(rdq1.size()), 64'd0);
    checkOutput("ovq0 drained", 64'(ovq0.size()), 64'd0);
    checkOutput("ovq1 drained", 64'(ovq1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
